// File: rtl/fifo_read_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO read port among NUM_REQ consumers.
// Latency: one IDLE cycle from request to grant, then one cycle from rd_ena to out_valid.
// Backpressure: stalls with the grant held while rd_empty is high; grantee drops req to release early.
module fifo_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  rd_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_ena,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_REQ-1:0]    out_valid,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

    logic [0:0]         state;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   last_idx;
    logic [CNT_W-1:0]   burst_cnt;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;

    logic               in_burst;
    logic               grantee_req;
    logic               final_beat;
    logic               burst_done;

    // Candidate index base+ofs modulo NUM_REQ; base < NUM_REQ and ofs <= NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int ofs);
        int sum;
        sum = base + ofs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    assign in_burst    = (state == S_BURST);
    assign grantee_req = req[gnt_idx];
    assign rd_ena      = in_burst & ~rd_empty & grantee_req;
    assign final_beat  = rd_ena & (burst_cnt == LAST_BEAT);
    assign burst_done  = final_beat | ~grantee_req;
    assign busy        = in_burst;

    // Search starts one past the last grantee so the most recent winner ranks lowest.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_vld && req[wrap_idx(int'(last_idx), k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_idx(int'(last_idx), k);
            end
        end
    end

    assign pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state     <= S_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            last_idx  <= LAST_RESET;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        state     <= S_BURST;
                        gnt       <= pick_oh;
                        gnt_idx   <= pick_idx;
                        burst_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (rd_ena) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                    if (burst_done) begin
                        state    <= S_IDLE;
                        gnt      <= '0;
                        last_idx <= gnt_idx;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Delivery path: out_valid is a one-cycle strobe per accepted word.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= rd_ena ? gnt : '0;
            if (rd_ena) begin
                out_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: directed vector tables, hand sequences and randomized traffic vs a reference model.
module tb_fifo_read_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          rd_empty;
    logic [DW-1:0] rd_data;
    logic          rd_ena;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_valid;
    logic          busy;

    fifo_read_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MAXB)
    ) dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .rd_empty (rd_empty),
        .rd_data  (rd_data),
        .rd_ena   (rd_ena),
        .req      (req),
        .gnt      (gnt),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        int            grp;
        logic [N-1:0]  req;
        logic          fe;
        logic [N-1:0]  gnt;
        logic          ena;
        logic [N-1:0]  ov;
        logic [DW-1:0] od;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] q[$];
    logic          frc_empty;
    int            errors = 0;
    int            checks = 0;

    // Reference model: grantee index (-1 when idle), reads taken, last grantee, registered outputs.
    int            mdl_g;
    int            mdl_last;
    int            mdl_cnt;
    logic [N-1:0]  mdl_ov;
    logic [DW-1:0] mdl_od;

    logic          s_ena;
    logic [N-1:0]  s_gnt;
    logic [N-1:0]  s_ov;
    logic [DW-1:0] s_od;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input int g, input logic [N-1:0] r, input logic fe,
                                input logic [N-1:0] gn, input logic en,
                                input logic [N-1:0] ov, input logic [DW-1:0] od);
        vec_t v;
        v.grp = g; v.req = r; v.fe = fe; v.gnt = gn; v.ena = en; v.ov = ov; v.od = od;
        return v;
    endfunction

    task automatic mdl_reset();
        mdl_g    = -1;
        mdl_last = N - 1;
        mdl_cnt  = 0;
        mdl_ov   = '0;
        mdl_od   = '0;
    endtask

    task automatic mdl_step(input logic ena);
        if (mdl_g < 0) begin
            mdl_ov = '0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (mdl_last + k) % N;
                if (mdl_g < 0 && req[idx]) begin
                    mdl_g   = idx;
                    mdl_cnt = 0;
                end
            end
        end else begin
            if (ena) begin
                mdl_od  = q[0];
                mdl_ov  = N'(1) << mdl_g;
                mdl_cnt = mdl_cnt + 1;
            end else begin
                mdl_ov = '0;
            end
            if ((ena && mdl_cnt == MAXB) || !req[mdl_g]) begin
                mdl_last = mdl_g;
                mdl_g    = -1;
            end
        end
    endtask

    task automatic drive_fifo();
        rd_empty = frc_empty || (q.size() == 0);
        rd_data  = (q.size() > 0) ? q[0] : '0;
    endtask

    task automatic fill(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back(base + DW'(i));
        end
    endtask

    // One clock cycle: sample and check at negedge, advance model, pop FIFO after the edge.
    task automatic cycle();
        logic         exp_ena;
        logic [N-1:0] exp_gnt;
        drive_fifo();
        @(negedge rd_clk);
        if (!rd_rst_n) mdl_reset();
        exp_ena = (mdl_g >= 0) ? (!rd_empty && req[mdl_g]) : 1'b0;
        exp_gnt = (mdl_g >= 0) ? (N'(1) << mdl_g) : '0;
        s_ena = rd_ena;
        s_gnt = gnt;
        s_ov  = out_valid;
        s_od  = out_data;
        chk("mdl_rd_ena", 32'(rd_ena), 32'(exp_ena));
        chk("mdl_gnt", 32'(gnt), 32'(exp_gnt));
        chk("mdl_busy", 32'(busy), 32'(mdl_g >= 0));
        chk("mdl_out_valid", 32'(out_valid), 32'(mdl_ov));
        chk("mdl_out_data", 32'(out_data), 32'(mdl_od));
        if (rd_rst_n) mdl_step(exp_ena);
        @(posedge rd_clk);
        #1;
        if (s_ena && q.size() > 0) void'(q.pop_front());
    endtask

    task automatic run_group(input int g, input string nm);
        int row;
        row = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].grp == g) begin
                req       = vecs[i].req;
                frc_empty = vecs[i].fe;
                cycle();
                chk($sformatf("%s_gnt[%0d]", nm, row), 32'(s_gnt), 32'(vecs[i].gnt));
                chk($sformatf("%s_ena[%0d]", nm, row), 32'(s_ena), 32'(vecs[i].ena));
                chk($sformatf("%s_ov[%0d]", nm, row), 32'(s_ov), 32'(vecs[i].ov));
                if (vecs[i].ov != '0)
                    chk($sformatf("%s_od[%0d]", nm, row), 32'(s_od), 32'(vecs[i].od));
                row++;
            end
        end
    endtask

    initial begin
        int rr_cnt[N];

        // Group 0: single consumer, six words, burst split at four.
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 8'h00));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 8'hA0));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 8'hA1));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 8'hA2));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 8'hA3));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 8'h00));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 8'hA4));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0010, 8'hA5));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 8'h00));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 8'h00));
        // Group 1: consumer 2 stalls on empty for three cycles after its second read.
        vecs.push_back(mk(1, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00));
        vecs.push_back(mk(1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 8'h00));
        vecs.push_back(mk(1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'h50));
        vecs.push_back(mk(1, 4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0100, 8'h51));
        vecs.push_back(mk(1, 4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0000, 8'h00));
        vecs.push_back(mk(1, 4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0000, 8'h00));
        vecs.push_back(mk(1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 8'h00));
        vecs.push_back(mk(1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'h52));
        vecs.push_back(mk(1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 8'h53));
        vecs.push_back(mk(1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00));
        // Group 2: consumer 3 releases early after two reads, then wrap to consumer 0.
        vecs.push_back(mk(2, 4'b1001, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00));
        vecs.push_back(mk(2, 4'b1001, 1'b0, 4'b1000, 1'b1, 4'b0000, 8'h00));
        vecs.push_back(mk(2, 4'b1001, 1'b0, 4'b1000, 1'b1, 4'b1000, 8'h60));
        vecs.push_back(mk(2, 4'b0001, 1'b0, 4'b1000, 1'b0, 4'b1000, 8'h61));
        vecs.push_back(mk(2, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00));
        vecs.push_back(mk(2, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 8'h00));
        vecs.push_back(mk(2, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0001, 8'h62));
        vecs.push_back(mk(2, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00));

        mdl_reset();
        rd_rst_n  = 1'b0;
        req       = 4'b1111;
        frc_empty = 1'b0;
        fill(8'h10, 8);

        // Reset holds everything quiet even with requests and data present.
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_rd_ena", 32'(s_ena), 32'd0);
            chk("rst_gnt", 32'(s_gnt), 32'd0);
            chk("rst_out_valid", 32'(s_ov), 32'd0);
            chk("rst_out_data", 32'(s_od), 32'd0);
        end
        rd_rst_n = 1'b1;
        cycle();
        req = 4'b0000;
        cycle();
        chk("first_gnt", 32'(s_gnt), 32'b0001);
        cycle();
        q.delete();

        fill(8'hA0, 6);
        run_group(0, "split");
        req = '0;
        cycle();
        cycle();
        q.delete();

        // Round robin from a fresh reset with all four requesting.
        rd_rst_n = 1'b0;
        cycle();
        rd_rst_n = 1'b1;
        fill(8'h20, 40);
        req = 4'b1111;
        for (int i = 0; i < N; i++) rr_cnt[i] = 0;
        for (int k = 0; k < 26; k++) begin
            cycle();
            chk($sformatf("rr_gnt[%0d]", k), 32'(s_gnt),
                32'((k % 5 == 0) ? 4'b0000 : (4'b0001 << ((k / 5) % 4))));
            chk($sformatf("rr_ena[%0d]", k), 32'(s_ena), 32'(k % 5 != 0));
            for (int i = 0; i < N; i++) if (s_ov[i]) rr_cnt[i]++;
        end
        chk("rr_words0", 32'(rr_cnt[0]), 32'd8);
        chk("rr_words1", 32'(rr_cnt[1]), 32'd4);
        chk("rr_words2", 32'(rr_cnt[2]), 32'd4);
        chk("rr_words3", 32'(rr_cnt[3]), 32'd4);
        req = '0;
        cycle();
        cycle();
        q.delete();

        fill(8'h50, 8);
        run_group(1, "stall");
        q.delete();

        fill(8'h60, 8);
        run_group(2, "release");
        q.delete();

        // Reset dropped during the third read of a burst to consumer 2.
        fill(8'h70, 8);
        req = 4'b0100;
        cycle();
        cycle();
        cycle();
        rd_rst_n = 1'b0;
        cycle();
        chk("rst_mid_ena", 32'(s_ena), 32'd0);
        chk("rst_mid_gnt", 32'(s_gnt), 32'd0);
        chk("rst_mid_ov", 32'(s_ov), 32'd0);
        cycle();
        chk("rst_mid_ov2", 32'(s_ov), 32'd0);
        rd_rst_n = 1'b1;
        req = 4'b1111;
        cycle();
        cycle();
        chk("rst_restart_gnt", 32'(s_gnt), 32'b0001);
        req = '0;
        cycle();
        cycle();
        q.delete();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            frc_empty = ($urandom_range(0, 4) == 0);
            rd_rst_n  = ($urandom_range(0, 399) != 0);
            if (q.size() < 3) begin
                for (int i = 0; i < 6; i++) q.push_back(DW'($urandom));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Round-robin arbiter that shares the read port of the asynchronous FIFO between several consumers in the read clock domain. It drives the FIFO read enable, samples the FIFO read data, and steers each word to the granted consumer. Grants are burst-limited, so no consumer can monopolise the FIFO. It sits between the FIFO read-pointer/memory side and the downstream consumers, and never reads an empty FIFO.

## Interface
- NUM_REQ, 4, number of consumers; legal range 2..8
- DATA_WIDTH, 8, FIFO word width
- MAX_BURST, 4, maximum reads per grant; must be ≥1
- rd_clk  input  1  read-domain clock, all logic on its rising edge
- rd_rst_n  input  1  asynchronous, active-low reset
- rd_empty  input  1  FIFO empty flag (registered, from the read-pointer block)
- rd_data  input  DATA_WIDTH  FIFO word at the current read address, valid combinationally while rd_empty=0
- rd_ena  output  1  FIFO read enable (combinational)
- req  input  NUM_REQ  per-consumer read request, level-sensitive
- gnt  output  NUM_REQ  registered one-hot grant, or 0 when idle
- out_data  output  DATA_WIDTH  registered word delivered to a consumer
- out_valid  output  NUM_REQ  registered one-hot strobe: out_data is valid for this consumer
- busy  output  1  high while in BURST

## Operation
- State machine with two states:
  - IDLE: gnt=0 and rd_ena=0. If req≠0, pick the first asserted req[i] searching upward (with wrap) from last+1. Load gnt with one-hot i, set burst_cnt to 0, and go to BURST. If req=0, stay in IDLE.
  - BURST: rd_ena = ~rd_empty & req[g], where g is the granted index. Each cycle with rd_ena=1 is one accepted read. On an accepted read:
    - out_data <= rd_data
    - out_valid <= gnt
    - burst_cnt increments
  - Leave BURST for IDLE at the edge where either of these holds:
    - an accepted read brings burst_cnt to MAX_BURST
    - req[g]=0
  - On leaving BURST: last <= g, gnt <= 0.
- rd_empty=1 in BURST: no read, burst_cnt held, grant held. The block stalls indefinitely until data arrives or the grantee drops req.
- req[g] dropping in the same cycle that rd_empty falls: no read; the block exits to IDLE.
- Requests from non-granted consumers are ignored until the next IDLE cycle.
- burst_cnt width is $clog2(MAX_BURST+1). Its compare is exact and the counter never wraps.
- last register: $clog2(NUM_REQ) bits; next-index arithmetic is modulo NUM_REQ.
- Reset values (asynchronous, immediate when rd_rst_n goes low):
  - state=IDLE
  - gnt=0, out_valid=0, out_data=0, busy=0
  - burst_cnt=0
  - last=NUM_REQ-1, so consumer 0 has first priority
  - rd_ena=0 immediately, because it is decoded from the state
- out_valid is a single-cycle pulse per word and is cleared in every cycle without an accepted read.

## Timing
- Cycle-level sequence for a request seen at edge T:
  - edge T: req sampled in IDLE
  - cycle T+1: gnt and busy high, and rd_ena may assert if the FIFO is not empty
  - following edge: FIFO pointer advances, out_data/out_valid register the word
  - data latency: one cycle from rd_ena to out_valid
- Back-to-back reads within a burst: one word per cycle.
- Between grants there is exactly one IDLE cycle with gnt=0. Sustained throughput is MAX_BURST/(MAX_BURST+1) with continuous requests.
- rd_ena depends combinationally on rd_empty, req and state only. It has no path from rd_data.
- rd_empty latency comes from the read-pointer block. The arbiter relies on rd_empty being registered and current for the cycle it is used.

## Test plan
- Reset: hold rd_rst_n=0 with req=4'b1111 and rd_empty=0 → rd_ena=0, gnt=0, out_valid=0, out_data=0. After release, the first grant is gnt=4'b0001.
- Single burst split: FIFO holds A0..A5, only req[1]=1, MAX_BURST=4.
  - gnt=4'b0010 with 4 consecutive rd_ena, then out_valid=4'b0010 carrying A0..A3
  - one cycle with gnt=0
  - regrant, then A4 and A5
  - then a stall with rd_ena=0 while rd_empty=1
- Round robin: req=4'b1111, FIFO kept non-empty → grant order 0,1,2,3,0. Each grant delivers exactly 4 words, with one idle cycle between grants.
- Empty stall: grant to consumer 2 and force rd_empty=1 for 3 cycles after its 2nd read.
  - during the stall: rd_ena=0, out_valid=0, gnt stays 4'b0100
  - afterwards: exactly 2 more words, then IDLE
- Early release: consumer 3 granted and drops req after 2 reads, with req[0]=1.
  - 2 strobes on out_valid[3]
  - IDLE at the next edge
  - next grant 4'b0001 (wrap from last=3)
- Reset mid-burst: assert rd_rst_n=0 during the 3rd read of a burst → rd_ena=0 in the same cycle, with no further out_valid. After release, priority restarts at consumer 0.
